// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage:
// funct3 load/store width codes, FSM states, default bus timeout.
package mem_access_pkg;

  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, extraction/extension for loads,
// and the alignment check on an incoming access.
import mem_access_pkg::*;

module mem_align (
  input  logic [1:0]  addr_i,
  input  logic [2:0]  width_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  chk_addr_i,
  input  logic [2:0]  chk_width_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = sdata_i;
    case (width_i)
      W_B, W_BU: begin
        wstrb_o = 4'b0001 << addr_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      W_H, W_HU: begin
        wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_s = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: ;
    endcase
    half_s = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    ldata_o = rdata_i;
    case (width_i)
      W_B:     ldata_o = {{24{byte_s[7]}}, byte_s};
      W_BU:    ldata_o = {24'd0, byte_s};
      W_H:     ldata_o = {{16{half_s[15]}}, half_s};
      W_HU:    ldata_o = {16'd0, half_s};
      default: ;
    endcase
  end

  // Unknown width codes behave as W, so they need full word alignment.
  always_comb begin
    misaligned_o = 1'b0;
    case (chk_width_i)
      W_B, W_BU: misaligned_o = 1'b0;
      W_H, W_HU: misaligned_o = chk_addr_i[0];
      default:   misaligned_o = |chk_addr_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: one req/ack data-bus transaction per load/store,
// stalling upstream until the access completes or times out.
import mem_access_pkg::*;

module mem_access_stage #(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] read_data_2_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  mem_width_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  width_q;
  logic [31:0] sdata_q;
  logic        we_q;
  logic [7:0]  cnt_q;
  logic [31:0] ldata_q;
  logic        lvalid_q;
  logic        mis_q;
  logic        berr_q;

  logic        access_s;
  logic        mis_s;
  logic        start_s;
  logic        ack_s;
  logic        tout_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_s;
  logic [31:0] ldata_s;

  mem_align u_align (
    .addr_i       (addr_q[1:0]),
    .width_i      (width_q),
    .sdata_i      (sdata_q),
    .rdata_i      (mem_rdata),
    .chk_addr_i   (ALU_result_in[1:0]),
    .chk_width_i  (mem_width_in),
    .wstrb_o      (wstrb_s),
    .wdata_o      (wdata_s),
    .ldata_o      (ldata_s),
    .misaligned_o (mis_s)
  );

  assign access_s = mem_read_in | mem_write_in;

  always_comb begin
    state_d   = state_q;
    start_s   = 1'b0;
    ack_s     = 1'b0;
    tout_s    = 1'b0;
    mem_req   = 1'b0;
    stall_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access_s && !mis_s && !rst) begin
          start_s   = 1'b1;
          stall_out = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        mem_req   = 1'b1;
        stall_out = 1'b1;
        if (mem_ack) begin
          ack_s   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          tout_s  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      width_q  <= '0;
      sdata_q  <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      ldata_q  <= '0;
      lvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvalid_q <= ack_s && !we_q;
      mis_q    <= (state_q == S_IDLE) && access_s && mis_s;
      berr_q   <= tout_s;
      if (start_s) begin
        addr_q  <= ALU_result_in;
        width_q <= mem_width_in;
        sdata_q <= read_data_2_in;
        we_q    <= mem_write_in;
        cnt_q   <= '0;
      end else if (state_q == S_REQ && !mem_ack) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (ack_s && !we_q) begin
        ldata_q <= ldata_s;
      end
    end
  end

  assign mem_we         = mem_req & we_q;
  assign mem_addr       = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata      = mem_we ? wdata_s : 32'd0;
  assign mem_wstrb      = mem_we ? wstrb_s : 4'd0;
  assign load_data_out  = ldata_q;
  assign load_valid_out = lvalid_q;
  assign misaligned_out = mis_q;
  assign bus_error_out  = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment,
// bus timeout and reset in the middle of an access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu;
  logic [31:0] sdata;
  logic        rd;
  logic        wr;
  logic [2:0]  width;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic [31:0] ldata;
  logic        lvalid;
  logic        mis;
  logic        berr;

  int errors = 0;
  int checks = 0;
  int cnt;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ALU_result_in  (alu),
    .read_data_2_in (sdata),
    .mem_read_in    (rd),
    .mem_write_in   (wr),
    .mem_width_in   (width),
    .mem_req        (req),
    .mem_we         (we),
    .mem_addr       (addr),
    .mem_wdata      (wdata),
    .mem_wstrb      (wstrb),
    .mem_ack        (ack),
    .mem_rdata      (rdata),
    .stall_out      (stall),
    .load_data_out  (ldata),
    .load_valid_out (lvalid),
    .misaligned_out (mis),
    .bus_error_out  (berr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag);
    chk({tag, ".req"}, {31'd0, req}, 32'd0);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".lvalid"}, {31'd0, lvalid}, 32'd0);
    chk({tag, ".mis"}, {31'd0, mis}, 32'd0);
    chk({tag, ".berr"}, {31'd0, berr}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a,
                         input logic [2:0] w, input logic [31:0] d,
                         input logic [31:0] exp);
    alu = a; width = w; rd = 1'b1; wr = 1'b0;
    #1;
    chk({tag, ".stall0"}, {31'd0, stall}, 32'd1);
    tick();
    chk({tag, ".req"}, {31'd0, req}, 32'd1);
    chk({tag, ".addr"}, addr, {a[31:2], 2'b00});
    ack = 1'b1; rdata = d;
    tick();
    ack = 1'b0; rd = 1'b0;
    chk({tag, ".data"}, ldata, exp);
    chk({tag, ".lvalid"}, {31'd0, lvalid}, 32'd1);
    chk({tag, ".stall_done"}, {31'd0, stall}, 32'd0);
    tick();
    chk({tag, ".lvalid_off"}, {31'd0, lvalid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; alu = '0; sdata = '0; rd = 1'b0; wr = 1'b0;
    width = 3'b010; ack = 1'b0; rdata = '0;
    tick();
    tick();
    quiet("reset");
    chk("reset.ldata", ldata, 32'd0);
    chk("reset.addr", addr, 32'd0);
    rst = 1'b0;
    tick();

    // LW 0x100, ack in first REQ cycle
    alu = 32'h100; width = 3'b010; rd = 1'b1;
    #1;
    chk("lw.stall0", {31'd0, stall}, 32'd1);
    chk("lw.noreq0", {31'd0, req}, 32'd0);
    tick();
    chk("lw.req", {31'd0, req}, 32'd1);
    chk("lw.stall1", {31'd0, stall}, 32'd1);
    chk("lw.addr", addr, 32'h100);
    chk("lw.wstrb", {28'd0, wstrb}, 32'd0);
    chk("lw.we", {31'd0, we}, 32'd0);
    ack = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    ack = 1'b0; rd = 1'b0;
    chk("lw.data", ldata, 32'hDEADBEEF);
    chk("lw.lvalid", {31'd0, lvalid}, 32'd1);
    chk("lw.stall_done", {31'd0, stall}, 32'd0);
    chk("lw.req_done", {31'd0, req}, 32'd0);
    tick();
    quiet("lw.after");
    chk("lw.hold", ldata, 32'hDEADBEEF);

    do_load("lb", 32'h103, 3'b000, 32'h80AABBCC, 32'hFFFFFF80);
    do_load("lbu", 32'h103, 3'b100, 32'h80AABBCC, 32'h00000080);
    do_load("lh", 32'h102, 3'b001, 32'h80AABBCC, 32'hFFFF80AA);
    do_load("lhu", 32'h100, 3'b101, 32'h80AABBCC, 32'h0000BBCC);
    do_load("lb0", 32'h101, 3'b000, 32'h1234567F, 32'h00000056);

    // SH 0x202, ack in the third REQ cycle
    cnt = 0;
    alu = 32'h202; sdata = 32'h1234ABCD; width = 3'b001; wr = 1'b1;
    #1;
    cnt += int'(stall);
    tick();
    chk("sh.req", {31'd0, req}, 32'd1);
    chk("sh.we", {31'd0, we}, 32'd1);
    chk("sh.addr", addr, 32'h200);
    chk("sh.wstrb", {28'd0, wstrb}, 32'hC);
    chk("sh.wdata", wdata, 32'hABCDABCD);
    cnt += int'(stall);
    tick();
    chk("sh.req2", {31'd0, req}, 32'd1);
    cnt += int'(stall);
    tick();
    chk("sh.req3", {31'd0, req}, 32'd1);
    cnt += int'(stall);
    ack = 1'b1;
    tick();
    ack = 1'b0; wr = 1'b0;
    cnt += int'(stall);
    chk("sh.stall_cycles", cnt, 32'd4);
    chk("sh.lvalid", {31'd0, lvalid}, 32'd0);
    chk("sh.berr", {31'd0, berr}, 32'd0);
    chk("sh.ldata_hold", ldata, 32'h00000056);
    tick();

    // read and write both high: store; SB lane 1
    alu = 32'h101; sdata = 32'h000000A5; width = 3'b000;
    rd = 1'b1; wr = 1'b1;
    tick();
    chk("sb.we", {31'd0, we}, 32'd1);
    chk("sb.wstrb", {28'd0, wstrb}, 32'h2);
    chk("sb.wdata", wdata, 32'hA5A5A5A5);
    ack = 1'b1;
    tick();
    ack = 1'b0; rd = 1'b0; wr = 1'b0;
    chk("sb.lvalid", {31'd0, lvalid}, 32'd0);
    tick();

    // misaligned LW 0x102
    alu = 32'h102; width = 3'b010; rd = 1'b1;
    #1;
    chk("mis.stall", {31'd0, stall}, 32'd0);
    chk("mis.req0", {31'd0, req}, 32'd0);
    tick();
    rd = 1'b0;
    chk("mis.pulse", {31'd0, mis}, 32'd1);
    chk("mis.req1", {31'd0, req}, 32'd0);
    chk("mis.stall1", {31'd0, stall}, 32'd0);
    tick();
    chk("mis.pulse_off", {31'd0, mis}, 32'd0);
    chk("mis.req2", {31'd0, req}, 32'd0);

    // timeout: no ack at all
    alu = 32'h300; width = 3'b010; rd = 1'b1;
    tick();
    cnt = 0;
    while (req && cnt < 20) begin
      cnt++;
      tick();
    end
    rd = 1'b0;
    chk("tout.req_cycles", cnt, 32'd4);
    chk("tout.berr", {31'd0, berr}, 32'd1);
    chk("tout.lvalid", {31'd0, lvalid}, 32'd0);
    chk("tout.ldata", ldata, 32'h00000056);
    chk("tout.stall", {31'd0, stall}, 32'd0);
    tick();
    chk("tout.berr_off", {31'd0, berr}, 32'd0);

    // reset during the second REQ cycle, late ack afterwards
    alu = 32'h400; width = 3'b010; rd = 1'b1;
    tick();
    tick();
    chk("rstreq.req2", {31'd0, req}, 32'd1);
    rst = 1'b1; rd = 1'b0;
    tick();
    rst = 1'b0;
    quiet("rstreq.reset");
    chk("rstreq.ldata", ldata, 32'd0);
    chk("rstreq.addr", addr, 32'd0);
    chk("rstreq.wstrb", {28'd0, wstrb}, 32'd0);
    ack = 1'b1; rdata = 32'h55AA55AA;
    tick();
    ack = 1'b0;
    quiet("rstreq.late_ack");
    chk("rstreq.ldata2", ldata, 32'd0);
    tick();
    quiet("rstreq.idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
